core_decode_pipe: RTL and testbench
===================================

# core_decode_pipe

Parametrised, handshaked instruction decode stage for the integer/FP core. It accepts one 32-bit instruction per cycle from fetch and decodes it into a compact micro-op (unit + function code, register numbers, write enables, immediate). The result is held in an output register backed by an optional skid entry, so fetch and issue are fully decoupled under backpressure and flush. It replaces the flat one-hot `I_*` decoder output with a dense, enable-gated encoding.

## Interface
- `FP_EN`, default 1: decode the FP opcodes (FLW, FSW, OP-FP); when 0 they are illegal.
- `CUSTOM_EN`, default 1: decode IN/OUT (opcode 0000001) and ROT (opcode 0001011); when 0 they are illegal.
- `SKID`, default 1: 1 = two-entry buffer with registered `IN_READY`; 0 = single register with combinational `IN_READY`.
- `PC_W`, default 32: PC width.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `FLUSH` in 1: discard all held and incoming instructions.
- `IN_VALID` in 1: instruction offered.
- `IN_READY` out 1: stage can accept.
- `IN_INST` in 32: instruction word.
- `IN_PC` in `PC_W`: instruction PC.
- `OUT_VALID` out 1: micro-op valid.
- `OUT_READY` in 1: consumer accepts.
- `OUT_PC` out `PC_W`, `OUT_INST` out 32: pass-through of PC and instruction.
- `OUT_UNIT` out 3, `OUT_FUNC` out 5: micro-op code.
- `OUT_RD` out 5, `OUT_RS1` out 5, `OUT_RS2` out 5: `INST[11:7]`, `INST[19:15]`, `INST[24:20]`.
- `OUT_RD_WE` out 1, `OUT_FRD_WE` out 1: integer / FP destination write enables.
- `OUT_IMM` out 32: sign-extended immediate.
- `OUT_ILLEGAL` out 1: undecodable instruction.

## Operation
- Decode is combinational on `IN_INST`; results are captured only when accepted (`IN_VALID && IN_READY && !FLUSH`).
- UNIT codes: 0 ALU, 1 BRANCH, 2 LSU, 3 JUMP, 4 FPU, 5 IO, 6 SYS, 7 ILLEGAL.
- ALU FUNC = {imm_form, funct7[5], funct3}.
  - OP-IMM has imm_form=1; funct7[5] is used only for SRAI (otherwise 0).
  - OP has imm_form=0.
  - Illegal cases: OP with funct7 not in {0x00, 0x20}; funct7 = 0x20 with funct3 not in {000, 101}; SLLI/SRLI/SRAI with funct7 not in the legal set.
- BRANCH FUNC = funct3. funct3 010 or 011 is illegal.
- LSU FUNC = {store, fp, funct3}.
  - Legal loads: funct3 000/001/010/100/101.
  - Legal stores: funct3 000/001/010.
  - FLW and FSW require funct3 = 010.
- JUMP FUNC: 0 JAL, 1 JALR, 2 LUI, 3 AUIPC.
- FPU FUNC: 0 FADD, 1 FSUB, 2 FMUL, 3 FDIV, 4 FSGNJX, 5 FSQRT, 6 FEQ, 7 FLT, 8 FLE, 9 FMVSX, 10 FCVTSW, 11 FCVTWS. Selection is by funct7, plus funct3 for the compare ops.
- IO FUNC: 0 IN, 1 OUT, 2 ROT. SYS FUNC: 0 FENCE, 1 FENCEI.
- Any unmatched encoding gives UNIT=7, FUNC=0, `OUT_ILLEGAL`=1, both write enables 0, IMM=0.
- `OUT_FRD_WE` = FLW, FADD, FSUB, FMUL, FDIV, FSGNJX, FSQRT, FMVSX or FCVTSW.
- `OUT_RD_WE` = 1 except for: branch, store, FSW, ILLEGAL, any op with `OUT_FRD_WE`=1, or `INST[11:7]`=0.
- IMM formats:
  - I-type: JALR, loads, OP-IMM, FLW, FENCE.
  - S-type: stores, FSW.
  - B-type: branches.
  - U-type: LUI, AUIPC.
  - J-type: JAL.
  - All other encodings: 0.
- Buffering with `SKID`=1:
  - `IN_READY` = !skid_valid, driven from a register.
  - An accepted word goes to the output register if it is empty or being drained this cycle; otherwise it goes to the skid entry.
  - When the output drains, a valid skid entry moves into the output register in the same edge.
  - Order is preserved.
- Buffering with `SKID`=0: `IN_READY` = !OUT_VALID || OUT_READY.
- FLUSH has priority over everything else. On the next edge both valids clear, and the same-cycle input is dropped. `IN_READY` is 1 in the cycle after a flush.

## Timing
- Latency: 1 cycle from acceptance to `OUT_VALID`.
- Throughput: 1 instruction/cycle when `OUT_READY`=1.
- `OUT_*` payload is stable while `OUT_VALID && !OUT_READY`.
- Reset values (asynchronous on `RST`): all outputs 0, except `IN_READY`=0 while `RST` is asserted and 1 after deassertion. Skid entry empty.
- Reset asserted mid-transfer: all buffered words are lost and no partial output is produced.
- Full condition (`SKID`=1): both entries valid and `OUT_READY`=0. Then `IN_READY`=0 and neither entry changes.
- Simultaneous skid→output move and new input acceptance is impossible, because `IN_READY`=0 whenever the skid entry is valid.

## Test plan
- ADDI x1,x0,5 (0x00500093), `OUT_READY`=1 → next cycle: `OUT_VALID`=1, UNIT=0, FUNC=16, RD=1, `RD_WE`=1, IMM=5.
- SUB x3,x1,x2 (0x402081B3) → UNIT=0, FUNC=8, RS1=1, RS2=2, `RD_WE`=1. BEQ x0,x0,-4 (0xFE000EE3) → UNIT=1, FUNC=0, IMM=0xFFFFFFFC, `RD_WE`=0.
- `SKID`=1: stream 3 instructions with `OUT_READY`=0 → `IN_READY` drops after 2 are accepted. Raise `OUT_READY` → all 3 emerge in order on consecutive cycles with payloads unchanged.
- FLUSH while both entries are full and `IN_VALID`=1 → next cycle `OUT_VALID`=0 and `IN_READY`=1. None of the flushed or the same-cycle instructions ever appear.
- `FP_EN`=0, FADD.S (0x00000053) → UNIT=7, `OUT_ILLEGAL`=1, both write enables 0. With `FP_EN`=1 → UNIT=4, FUNC=0, `FRD_WE`=1, `RD_WE`=0.
- Assert `RST` mid-stream while `OUT_VALID`=1 → outputs clear immediately. ADDI x0,x0,0 after reset → `RD_WE`=0.

Source files
------------

// File: rtl/core_decode_pipe.sv
// ---------------------------------------------------------------------------
// core_decode_pipe
//
// Instruction decode stage between fetch and issue. Each accepted 32-bit
// instruction is decoded combinationally into a dense micro-op (unit +
// function code, register numbers, write enables, immediate) and captured
// in an output register. With SKID=1 a second entry absorbs one extra word
// so IN_READY can come straight from a flop; with SKID=0 a single register
// is used and IN_READY is combinational.
//
// Parameters
//   FP_EN      1 = decode FLW / FSW / OP-FP, 0 = treat them as illegal
//   CUSTOM_EN  1 = decode IN / OUT / ROT,    0 = treat them as illegal
//   SKID       1 = two-entry buffer, 0 = single output register
//   PC_W       width of the instruction PC
//
// Ports
//   CLK, RST            clock (rising edge), async active-high reset
//   FLUSH               drop every held and same-cycle instruction
//   IN_VALID/IN_READY   fetch-side handshake
//   IN_INST, IN_PC      instruction word and its PC
//   OUT_VALID/OUT_READY issue-side handshake
//   OUT_PC, OUT_INST    pass-through of PC and instruction word
//   OUT_UNIT, OUT_FUNC  micro-op code (unit 7 = illegal)
//   OUT_RD/RS1/RS2      register fields of the instruction
//   OUT_RD_WE           integer destination write enable
//   OUT_FRD_WE          FP destination write enable
//   OUT_IMM             sign-extended immediate
//   OUT_ILLEGAL         instruction could not be decoded
// ---------------------------------------------------------------------------
module core_decode_pipe #(
    parameter bit FP_EN     = 1'b1,
    parameter bit CUSTOM_EN = 1'b1,
    parameter bit SKID      = 1'b1,
    parameter int PC_W      = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     IN_INST,
    input  logic [PC_W-1:0] IN_PC,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [PC_W-1:0] OUT_PC,
    output logic [31:0]     OUT_INST,
    output logic [2:0]      OUT_UNIT,
    output logic [4:0]      OUT_FUNC,
    output logic [4:0]      OUT_RD,
    output logic [4:0]      OUT_RS1,
    output logic [4:0]      OUT_RS2,
    output logic            OUT_RD_WE,
    output logic            OUT_FRD_WE,
    output logic [31:0]     OUT_IMM,
    output logic            OUT_ILLEGAL
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_FLW    = 7'b0000111;
    localparam logic [6:0] OPC_FSW    = 7'b0100111;
    localparam logic [6:0] OPC_OPFP   = 7'b1010011;
    localparam logic [6:0] OPC_IO     = 7'b0000001;
    localparam logic [6:0] OPC_ROT    = 7'b0001011;

    localparam logic [2:0] UNIT_ALU     = 3'd0;
    localparam logic [2:0] UNIT_BRANCH  = 3'd1;
    localparam logic [2:0] UNIT_LSU     = 3'd2;
    localparam logic [2:0] UNIT_JUMP    = 3'd3;
    localparam logic [2:0] UNIT_FPU     = 3'd4;
    localparam logic [2:0] UNIT_IO      = 3'd5;
    localparam logic [2:0] UNIT_SYS     = 3'd6;
    localparam logic [2:0] UNIT_ILLEGAL = 3'd7;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
        logic [2:0]      unit;
        logic [4:0]      func;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rdWe;
        logic            frdWe;
        logic [31:0]     imm;
        logic            illegal;
    } uop_t;

    // Instruction fields and the five immediate formats
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_immI;
    logic [31:0] w_immS;
    logic [31:0] w_immB;
    logic [31:0] w_immU;
    logic [31:0] w_immJ;

    assign w_opcode = IN_INST[6:0];
    assign w_funct3 = IN_INST[14:12];
    assign w_funct7 = IN_INST[31:25];
    assign w_immI   = {{20{IN_INST[31]}}, IN_INST[31:20]};
    assign w_immS   = {{20{IN_INST[31]}}, IN_INST[31:25], IN_INST[11:7]};
    assign w_immB   = {{19{IN_INST[31]}}, IN_INST[31], IN_INST[7],
                       IN_INST[30:25], IN_INST[11:8], 1'b0};
    assign w_immU   = {IN_INST[31:12], 12'b0};
    assign w_immJ   = {{11{IN_INST[31]}}, IN_INST[31], IN_INST[19:12],
                       IN_INST[20], IN_INST[30:21], 1'b0};

    // Raw decode: each opcode sets its unit/func/imm and a legality flag.
    // Anything not explicitly matched stays illegal; the illegal gating is
    // applied afterwards in one place so no branch needs to clear fields.
    logic        w_legal;
    logic [2:0]  w_unit;
    logic [4:0]  w_func;
    logic [31:0] w_imm;
    logic        w_frdWe;
    logic        w_noRdWe;

    always_comb begin
        w_legal  = 1'b0;
        w_unit   = UNIT_ILLEGAL;
        w_func   = 5'd0;
        w_imm    = 32'd0;
        w_frdWe  = 1'b0;
        w_noRdWe = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_legal = 1'b1;
                w_unit  = UNIT_JUMP;
                w_func  = 5'd2;
                w_imm   = w_immU;
            end
            OPC_AUIPC: begin
                w_legal = 1'b1;
                w_unit  = UNIT_JUMP;
                w_func  = 5'd3;
                w_imm   = w_immU;
            end
            OPC_JAL: begin
                w_legal = 1'b1;
                w_unit  = UNIT_JUMP;
                w_func  = 5'd0;
                w_imm   = w_immJ;
            end
            OPC_JALR: begin
                w_legal = (w_funct3 == 3'b000);
                w_unit  = UNIT_JUMP;
                w_func  = 5'd1;
                w_imm   = w_immI;
            end
            OPC_BRANCH: begin
                w_legal  = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
                w_unit   = UNIT_BRANCH;
                w_func   = {2'b00, w_funct3};
                w_imm    = w_immB;
                w_noRdWe = 1'b1;
            end
            OPC_LOAD: begin
                w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                          (w_funct3 == 3'b010) || (w_funct3 == 3'b100) ||
                          (w_funct3 == 3'b101);
                w_unit  = UNIT_LSU;
                w_func  = {2'b00, w_funct3};
                w_imm   = w_immI;
            end
            OPC_STORE: begin
                w_legal  = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                           (w_funct3 == 3'b010);
                w_unit   = UNIT_LSU;
                w_func   = {2'b10, w_funct3};
                w_imm    = w_immS;
                w_noRdWe = 1'b1;
            end
            OPC_OPIMM: begin
                // Shift-immediates reuse funct7 as an opcode extension, so
                // only they constrain it; funct7[5] only matters for SRAI.
                if (w_funct3 == 3'b001) begin
                    w_legal = (w_funct7 == 7'h00);
                end else if (w_funct3 == 3'b101) begin
                    w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
                end else begin
                    w_legal = 1'b1;
                end
                w_unit = UNIT_ALU;
                w_func = {1'b1, (w_funct3 == 3'b101) && w_funct7[5], w_funct3};
                w_imm  = w_immI;
            end
            OPC_OP: begin
                w_legal = (w_funct7 == 7'h00) ||
                          ((w_funct7 == 7'h20) &&
                           ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
                w_unit  = UNIT_ALU;
                w_func  = {1'b0, w_funct7[5], w_funct3};
            end
            OPC_FENCE: begin
                w_unit = UNIT_SYS;
                if (w_funct3 == 3'b000) begin
                    w_legal = 1'b1;
                    w_func  = 5'd0;
                    w_imm   = w_immI;
                end else if (w_funct3 == 3'b001) begin
                    w_legal = 1'b1;
                    w_func  = 5'd1;
                end
            end
            OPC_FLW: begin
                w_legal = FP_EN && (w_funct3 == 3'b010);
                w_unit  = UNIT_LSU;
                w_func  = {2'b01, w_funct3};
                w_imm   = w_immI;
                w_frdWe = 1'b1;
            end
            OPC_FSW: begin
                w_legal  = FP_EN && (w_funct3 == 3'b010);
                w_unit   = UNIT_LSU;
                w_func   = {2'b11, w_funct3};
                w_imm    = w_immS;
                w_noRdWe = 1'b1;
            end
            OPC_OPFP: begin
                w_unit = UNIT_FPU;
                case (w_funct7)
                    7'b0000000: begin w_legal = 1'b1; w_func = 5'd0;  w_frdWe = 1'b1; end
                    7'b0000100: begin w_legal = 1'b1; w_func = 5'd1;  w_frdWe = 1'b1; end
                    7'b0001000: begin w_legal = 1'b1; w_func = 5'd2;  w_frdWe = 1'b1; end
                    7'b0001100: begin w_legal = 1'b1; w_func = 5'd3;  w_frdWe = 1'b1; end
                    7'b0010000: begin w_legal = 1'b1; w_func = 5'd4;  w_frdWe = 1'b1; end
                    7'b0101100: begin w_legal = 1'b1; w_func = 5'd5;  w_frdWe = 1'b1; end
                    7'b1111000: begin w_legal = 1'b1; w_func = 5'd9;  w_frdWe = 1'b1; end
                    7'b1101000: begin w_legal = 1'b1; w_func = 5'd10; w_frdWe = 1'b1; end
                    7'b1100000: begin w_legal = 1'b1; w_func = 5'd11; end
                    7'b1010000: begin
                        // Compares share funct7 and write the integer file
                        case (w_funct3)
                            3'b010:  begin w_legal = 1'b1; w_func = 5'd6; end
                            3'b001:  begin w_legal = 1'b1; w_func = 5'd7; end
                            3'b000:  begin w_legal = 1'b1; w_func = 5'd8; end
                            default: w_legal = 1'b0;
                        endcase
                    end
                    default: w_legal = 1'b0;
                endcase
                w_legal = w_legal && FP_EN;
            end
            OPC_IO: begin
                w_unit = UNIT_IO;
                if (w_funct3 == 3'b000) begin
                    w_legal = CUSTOM_EN;
                    w_func  = 5'd0;
                end else if (w_funct3 == 3'b001) begin
                    w_legal = CUSTOM_EN;
                    w_func  = 5'd1;
                end
            end
            OPC_ROT: begin
                w_legal = CUSTOM_EN;
                w_unit  = UNIT_IO;
                w_func  = 5'd2;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Final micro-op: illegal encodings collapse to a fixed all-zero payload
    // with unit 7, and the integer write enable is suppressed for x0.
    uop_t w_dec;

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = IN_PC;
        w_dec.inst    = IN_INST;
        w_dec.rd      = IN_INST[11:7];
        w_dec.rs1     = IN_INST[19:15];
        w_dec.rs2     = IN_INST[24:20];
        w_dec.illegal = !w_legal;
        w_dec.unit    = w_legal ? w_unit : UNIT_ILLEGAL;
        w_dec.func    = w_legal ? w_func : 5'd0;
        w_dec.imm     = w_legal ? w_imm  : 32'd0;
        w_dec.frdWe   = w_legal && w_frdWe;
        w_dec.rdWe    = w_legal && !w_noRdWe && !w_frdWe &&
                        (IN_INST[11:7] != 5'd0);
    end

    // Buffer state
    logic r_outValid;
    logic r_skidValid;
    logic r_inReady;
    uop_t r_out;
    uop_t r_skid;

    logic w_inReady;
    logic w_accept;
    logic w_drain;
    logic w_outValidNext;
    logic w_skidValidNext;
    logic w_loadOutIn;
    logic w_loadOutSkid;
    logic w_loadSkid;

    // IN_READY is forced low while reset is held so fetch never sees a
    // ready stage before the buffers are known empty.
    assign w_inReady = SKID ? (r_inReady && !RST)
                            : ((!r_outValid || OUT_READY) && !RST);
    assign w_accept  = IN_VALID && w_inReady && !FLUSH;
    assign w_drain   = r_outValid && OUT_READY;

    // Buffer control. The skid entry only fills when the output register is
    // held, and it always drains into the output register before new input
    // is taken, which keeps instructions in order.
    always_comb begin
        w_outValidNext  = r_outValid;
        w_skidValidNext = r_skidValid;
        w_loadOutIn     = 1'b0;
        w_loadOutSkid   = 1'b0;
        w_loadSkid      = 1'b0;
        if (FLUSH) begin
            w_outValidNext  = 1'b0;
            w_skidValidNext = 1'b0;
        end else if (SKID) begin
            if (!r_outValid || w_drain) begin
                if (r_skidValid) begin
                    w_loadOutSkid   = 1'b1;
                    w_outValidNext  = 1'b1;
                    w_skidValidNext = 1'b0;
                end else if (w_accept) begin
                    w_loadOutIn    = 1'b1;
                    w_outValidNext = 1'b1;
                end else begin
                    w_outValidNext = 1'b0;
                end
            end else if (w_accept) begin
                w_loadSkid      = 1'b1;
                w_skidValidNext = 1'b1;
            end
        end else begin
            if (!r_outValid || OUT_READY) begin
                w_outValidNext = w_accept;
                w_loadOutIn    = w_accept;
            end
        end
    end

    // Payload registers only load on a transfer, so a stalled output keeps
    // its payload stable for the consumer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
            r_inReady   <= 1'b1;
            r_out       <= '0;
            r_skid      <= '0;
        end else begin
            r_outValid  <= w_outValidNext;
            r_skidValid <= w_skidValidNext;
            r_inReady   <= !w_skidValidNext;
            if (w_loadOutIn) begin
                r_out <= w_dec;
            end else if (w_loadOutSkid) begin
                r_out <= r_skid;
            end
            if (w_loadSkid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign IN_READY    = w_inReady;
    assign OUT_VALID   = r_outValid;
    assign OUT_PC      = r_out.pc;
    assign OUT_INST    = r_out.inst;
    assign OUT_UNIT    = r_out.unit;
    assign OUT_FUNC    = r_out.func;
    assign OUT_RD      = r_out.rd;
    assign OUT_RS1     = r_out.rs1;
    assign OUT_RS2     = r_out.rs2;
    assign OUT_RD_WE   = r_out.rdWe;
    assign OUT_FRD_WE  = r_out.frdWe;
    assign OUT_IMM     = r_out.imm;
    assign OUT_ILLEGAL = r_out.illegal;

endmodule

// File: tb/tb_core_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_core_decode_pipe
//
// Bench for core_decode_pipe. The main instance uses the default parameters
// (FP and custom ops enabled, skid buffer on); a second instance with FP and
// custom ops disabled and no skid entry shares the same inputs. Every
// accepted instruction of the main instance pushes its hand-decoded
// micro-op onto a queue, and a monitor pops and compares whenever the main
// instance hands a micro-op to the consumer.
// ---------------------------------------------------------------------------
module tb_core_decode_pipe;

    localparam int PC_W = 32;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            FLUSH = 1'b0;
    logic            IN_VALID = 1'b0;
    logic [31:0]     IN_INST = '0;
    logic [PC_W-1:0] IN_PC = '0;
    logic            OUT_READY = 1'b0;

    logic            IN_READY, OUT_VALID, OUT_RD_WE, OUT_FRD_WE, OUT_ILLEGAL;
    logic [PC_W-1:0] OUT_PC;
    logic [31:0]     OUT_INST, OUT_IMM;
    logic [2:0]      OUT_UNIT;
    logic [4:0]      OUT_FUNC, OUT_RD, OUT_RS1, OUT_RS2;

    logic            nfInReady, nfOutValid, nfRdWe, nfFrdWe, nfIllegal;
    logic [PC_W-1:0] nfPc;
    logic [31:0]     nfInst, nfImm;
    logic [2:0]      nfUnit;
    logic [4:0]      nfFunc, nfRd, nfRs1, nfRs2;

    core_decode_pipe #(.FP_EN(1'b1), .CUSTOM_EN(1'b1), .SKID(1'b1), .PC_W(PC_W)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INST(IN_INST), .IN_PC(IN_PC),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PC(OUT_PC), .OUT_INST(OUT_INST),
        .OUT_UNIT(OUT_UNIT), .OUT_FUNC(OUT_FUNC), .OUT_RD(OUT_RD), .OUT_RS1(OUT_RS1),
        .OUT_RS2(OUT_RS2), .OUT_RD_WE(OUT_RD_WE), .OUT_FRD_WE(OUT_FRD_WE),
        .OUT_IMM(OUT_IMM), .OUT_ILLEGAL(OUT_ILLEGAL)
    );

    core_decode_pipe #(.FP_EN(1'b0), .CUSTOM_EN(1'b0), .SKID(1'b0), .PC_W(PC_W)) dutNoFp (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(nfInReady), .IN_INST(IN_INST), .IN_PC(IN_PC),
        .OUT_VALID(nfOutValid), .OUT_READY(OUT_READY), .OUT_PC(nfPc), .OUT_INST(nfInst),
        .OUT_UNIT(nfUnit), .OUT_FUNC(nfFunc), .OUT_RD(nfRd), .OUT_RS1(nfRs1),
        .OUT_RS2(nfRs2), .OUT_RD_WE(nfRdWe), .OUT_FRD_WE(nfFrdWe),
        .OUT_IMM(nfImm), .OUT_ILLEGAL(nfIllegal)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
        logic [2:0]      unit;
        logic [4:0]      func;
        logic            rdWe;
        logic            frdWe;
        logic [31:0]     imm;
        logic            ill;
    } exp_t;

    exp_t            sb[$];
    exp_t            cur;
    exp_t            monExp;
    int              checks = 0;
    int              errors = 0;
    bit              lastAccept;
    bit              lastFire;
    logic [PC_W-1:0] pcCount = 32'h0000_1000;
    logic [121:0]    monGot;
    logic [121:0]    monReq;

    function automatic exp_t mk(input logic [31:0] inst, input logic [2:0] unit,
                                input logic [4:0] func, input logic rdWe,
                                input logic frdWe, input logic [31:0] imm,
                                input logic ill);
        exp_t e;
        e.pc    = '0;
        e.inst  = inst;
        e.unit  = unit;
        e.func  = func;
        e.rdWe  = rdWe;
        e.frdWe = frdWe;
        e.imm   = imm;
        e.ill   = ill;
        return e;
    endfunction

    // Scoreboard monitor: compares every micro-op handed to the consumer
    always @(negedge CLK) begin
        #1;
        if (!RST && OUT_VALID && OUT_READY) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_output got inst=%h pc=%h, required no output",
                         OUT_INST, OUT_PC);
            end else begin
                monExp = sb.pop_front();
                monGot = {OUT_PC, OUT_INST, OUT_UNIT, OUT_FUNC, OUT_RD, OUT_RS1, OUT_RS2,
                          OUT_RD_WE, OUT_FRD_WE, OUT_IMM, OUT_ILLEGAL};
                monReq = {monExp.pc, monExp.inst, monExp.unit, monExp.func,
                          monExp.inst[11:7], monExp.inst[19:15], monExp.inst[24:20],
                          monExp.rdWe, monExp.frdWe, monExp.imm, monExp.ill};
                if (monGot !== monReq) begin
                    errors++;
                    $display("[TB] FAIL uop inst=%h got %h required %h",
                             monExp.inst, monGot, monReq);
                end
            end
        end
    end

    // One cycle: record handshakes shortly after the inputs settle, then
    // advance to the next falling edge.
    task automatic step();
        #1;
        lastFire   = OUT_VALID && OUT_READY;
        lastAccept = IN_VALID && IN_READY && !FLUSH;
        if (lastAccept) sb.push_back(cur);
        if (FLUSH) sb.delete();
        @(negedge CLK);
    endtask

    task automatic offer(input exp_t e);
        e.pc     = pcCount;
        pcCount  = pcCount + 4;
        cur      = e;
        IN_VALID = 1'b1;
        IN_INST  = e.inst;
        IN_PC    = e.pc;
    endtask

    task automatic send(input exp_t e);
        int n;
        n = 0;
        offer(e);
        do begin
            step();
            n++;
        end while (!lastAccept && n < 20);
        if (!lastAccept) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout inst=%h got no acceptance, required acceptance", e.inst);
        end
        IN_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if ({IN_READY, OUT_VALID, OUT_PC, OUT_INST, OUT_UNIT, OUT_FUNC, OUT_RD, OUT_RS1,
             OUT_RS2, OUT_RD_WE, OUT_FRD_WE, OUT_IMM, OUT_ILLEGAL} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got ready=%b valid=%b inst=%h unit=%0d, required all zero",
                     IN_READY, OUT_VALID, OUT_INST, OUT_UNIT);
        end
        checks++;
        if ({nfInReady, nfOutValid, nfInst, nfUnit, nfIllegal} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_nofp got ready=%b valid=%b, required zero",
                     nfInReady, nfOutValid);
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release got ready=%b valid=%b, required ready=1 valid=0",
                     IN_READY, OUT_VALID);
        end
        @(negedge CLK);
    endtask

    task automatic test_decode();
        exp_t tbl[$];
        tbl.push_back(mk(32'h00500093, 3'd0, 5'd16, 1'b1, 1'b0, 32'h0000_0005, 1'b0));
        tbl.push_back(mk(32'h402081B3, 3'd0, 5'd8,  1'b1, 1'b0, 32'h0000_0000, 1'b0));
        tbl.push_back(mk(32'hFE000EE3, 3'd1, 5'd0,  1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0));
        tbl.push_back(mk(32'h123452B7, 3'd3, 5'd2,  1'b1, 1'b0, 32'h1234_5000, 1'b0));
        tbl.push_back(mk(32'h4033D313, 3'd0, 5'd29, 1'b1, 1'b0, 32'h0000_0403, 1'b0));
        tbl.push_back(mk(32'h0020A423, 3'd2, 5'd18, 1'b0, 1'b0, 32'h0000_0008, 1'b0));
        tbl.push_back(mk(32'h023100B3, 3'd7, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b1));
        tbl.push_back(mk(32'h00002063, 3'd7, 5'd0,  1'b0, 1'b0, 32'h0000_0000, 1'b1));
        tbl.push_back(mk(32'h010000EF, 3'd3, 5'd0,  1'b1, 1'b0, 32'h0000_0010, 1'b0));
        tbl.push_back(mk(32'hFFC12203, 3'd2, 5'd2,  1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0));
        tbl.push_back(mk(32'hA020A2D3, 3'd4, 5'd6,  1'b1, 1'b0, 32'h0000_0000, 1'b0));
        tbl.push_back(mk(32'h0000100F, 3'd6, 5'd1,  1'b0, 1'b0, 32'h0000_0000, 1'b0));
        OUT_READY = 1'b1;
        foreach (tbl[i]) send(tbl[i]);
        idle(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL decode_drain got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back_skid();
        int fires;
        bit cAccepted;
        OUT_READY = 1'b0;
        send(mk(32'h00100093, 3'd0, 5'd16, 1'b1, 1'b0, 32'd1, 1'b0));
        send(mk(32'h00200113, 3'd0, 5'd16, 1'b1, 1'b0, 32'd2, 1'b0));
        offer(mk(32'h00300193, 3'd0, 5'd16, 1'b1, 1'b0, 32'd3, 1'b0));
        #1;
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skid_full_ready got %b, required 0", IN_READY);
        end
        step();
        step();
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_INST !== 32'h00100093 || OUT_IMM !== 32'd1 || lastAccept) begin
            errors++;
            $display("[TB] FAIL skid_stall_payload got valid=%b inst=%h imm=%h acc=%b, required 1 00100093 1 0",
                     OUT_VALID, OUT_INST, OUT_IMM, lastAccept);
        end
        OUT_READY = 1'b1;
        fires = 0;
        cAccepted = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (lastFire) fires++;
            if (lastAccept) begin
                cAccepted = 1'b1;
                IN_VALID  = 1'b0;
            end
        end
        checks++;
        if (fires != 3 || !cAccepted) begin
            errors++;
            $display("[TB] FAIL skid_drain got fires=%0d accepted=%b, required fires=3 accepted=1",
                     fires, cAccepted);
        end
        idle(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL skid_pending got %0d, required 0", sb.size());
        end
    endtask

    task automatic test_flush();
        OUT_READY = 1'b0;
        send(mk(32'h00400213, 3'd0, 5'd16, 1'b1, 1'b0, 32'd4, 1'b0));
        send(mk(32'h00500293, 3'd0, 5'd16, 1'b1, 1'b0, 32'd5, 1'b0));
        offer(mk(32'h00600313, 3'd0, 5'd16, 1'b1, 1'b0, 32'd6, 1'b0));
        FLUSH = 1'b1;
        step();
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_full got valid=%b ready=%b, required valid=0 ready=1",
                     OUT_VALID, IN_READY);
        end
        step();
        offer(mk(32'h00700393, 3'd0, 5'd16, 1'b1, 1'b0, 32'd7, 1'b0));
        FLUSH = 1'b1;
        step();
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_same_cycle got valid=%b, required 0", OUT_VALID);
        end
        OUT_READY = 1'b1;
        idle(4);
    endtask

    task automatic test_fp_enable();
        OUT_READY = 1'b1;
        send(mk(32'h00000053, 3'd4, 5'd0, 1'b0, 1'b1, 32'd0, 1'b0));
        #1;
        checks++;
        if (nfOutValid !== 1'b1 || nfUnit !== 3'd7 || nfIllegal !== 1'b1 ||
            nfRdWe !== 1'b0 || nfFrdWe !== 1'b0 || nfFunc !== 5'd0) begin
            errors++;
            $display("[TB] FAIL fp_disabled got valid=%b unit=%0d ill=%b we=%b fwe=%b func=%0d, required 1 7 1 0 0 0",
                     nfOutValid, nfUnit, nfIllegal, nfRdWe, nfFrdWe, nfFunc);
        end
        idle(2);
    endtask

    task automatic test_reset_midstream();
        OUT_READY = 1'b0;
        send(mk(32'h00100093, 3'd0, 5'd16, 1'b1, 1'b0, 32'd1, 1'b0));
        send(mk(32'h00200113, 3'd0, 5'd16, 1'b1, 1'b0, 32'd2, 1'b0));
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || OUT_INST !== 32'd0 || OUT_RD_WE !== 1'b0 || IN_READY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async got valid=%b inst=%h we=%b ready=%b, required 0 0 0 0",
                     OUT_VALID, OUT_INST, OUT_RD_WE, IN_READY);
        end
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_midstream_release got ready=%b valid=%b, required 1 0",
                     IN_READY, OUT_VALID);
        end
        OUT_READY = 1'b1;
        send(mk(32'h00000013, 3'd0, 5'd16, 1'b0, 1'b0, 32'd0, 1'b0));
        idle(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_midstream_pending got %0d, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back_skid();
        test_flush();
        test_fp_enable();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
